sprite_sequencer: RTL and testbench
===================================

Name: sprite_sequencer

Overview:
- Upstream feeder for the HDMI graphics stage: holds the table of on-screen sprites written by game logic.
- Once per video frame, during blanking, streams each active sprite's (x, y, absolute frame number) to the graphics stage over a valid/ready handshake.
- Owns sprite animation: a per-entry phase advances every ANIM_DIV video frames and wraps at the entry's animation length.

Parameters:
- MAX_SPRITES, 16, number of table entries; index width IW = $clog2(MAX_SPRITES).
- NUM_FRAMES, 512, total spritesheet frames; frame width FW = $clog2(NUM_FRAMES).
- WIDTH, 1280, screen width; x width XW = $clog2(WIDTH).
- HEIGHT, 720, screen height; y width YW = $clog2(HEIGHT).
- ANIM_DIV, 6, video frames per animation step (>=1).
- MAX_ANIM_LEN, 8, maximum frames in one animation; length width LW = $clog2(MAX_ANIM_LEN+1).

Ports:
- clk_pixel  in  1  pixel clock; the only clock.
- sys_rst  in  1  asynchronous, active-high reset.
- new_frame  in  1  single-cycle pulse at start of vertical blank.
- wr_en  in  1  table write strobe.
- wr_index  in  IW  entry to write.
- wr_active  in  1  entry enable.
- wr_x  in  XW  sprite x.
- wr_y  in  YW  sprite y.
- wr_base_frame  in  FW  first spritesheet frame of the animation.
- wr_anim_len  in  LW  animation length in frames.
- sprite_ready  in  1  downstream accepts the current sprite.
- sprite_valid  out  1  output sprite is valid.
- sprite_x  out  XW  sprite x.
- sprite_y  out  YW  sprite y.
- sprite_frame_number  out  FW  absolute frame = base + phase.
- sprite_index  out  IW  table entry being presented.
- busy  out  1  a scan is in progress.
- list_done  out  1  single-cycle pulse when a scan completes.
- overrun  out  1  sticky: new_frame arrived while busy.

Behaviour:
- Reset (async, immediate):
  - Outputs: all table entries inactive with phase 0; anim divider 0; step flag 0; state IDLE.
  - sprite_valid, busy, list_done, overrun, sprite_x, sprite_y, sprite_frame_number and sprite_index all 0.
  - Reset asserted mid-scan aborts the scan immediately.
- States:
  - IDLE:
    - new_frame at edge t: if divider == ANIM_DIV-1, divider<=0 and step<=1; else divider+1 and step<=0.
    - scan_idx<=0; go to SCAN; busy=1 from t+1.
  - SCAN:
    - One entry is inspected per cycle; inactive entries are skipped (one cycle each).
    - An active entry loads the output registers; sprite_valid rises the following cycle.
    - Output register refills when empty or on handshake (valid & ready), giving one sprite/cycle throughput with ready held high.
  - DRAIN:
    - Entered after index MAX_SPRITES-1 is inspected; waits for the last handshake.
    - Then goes to IDLE: busy<=0, list_done pulses for 1 cycle, in the same cycle busy falls.
- Handshake:
  - Once sprite_valid=1, all sprite_* outputs are stable until the cycle of sprite_ready=1.
  - Deasserting valid without a handshake is forbidden.
- Animation:
  - On handshake of entry i with step=1: phase_i <= (phase_i+1 >= len_eff) ? 0 : phase_i+1.
  - len_eff = max(wr_anim_len, 1).
  - The phase advance applies to the next scan; the current output uses the pre-advance phase.
- Frame arithmetic:
  - sprite_frame_number = (base + phase) mod NUM_FRAMES, truncated to FW bits with no saturation.
- Writes (any state):
  - Update the entry and force phase_i<=0.
  - A write to an entry currently held on the outputs does not alter those outputs.
  - Write plus handshake on the same entry in the same cycle: the write wins, so phase=0 and no advance.
  - A write to an already-inspected index during a scan takes effect next scan.
  - A write to a not-yet-inspected index is seen this scan.
- new_frame while state != IDLE:
  - Ignored, with no divider change; overrun<=1 (sticky until reset).
- All entries inactive: scan takes MAX_SPRITES cycles with valid never high, then list_done pulses.

Test Plan:
- Reset mid-scan with valid=1 -> all outputs 0 in the same cycle; after release and a new_frame, the scan restarts at index 0.
- Entries 0, 3, 15 active (x=10/20/30), ready=1, new_frame -> exactly 3 handshakes in order idx 0, 3, 15, then list_done pulses once and busy falls the same cycle.
- Entry 0: base=100, len=4, ANIM_DIV=2; 10 new_frames, each scan completed -> frame_number sequence 100, 100, 101, 101, 102, 102, 103, 103, 100, 100.
- Ready held low 50 cycles while valid -> x/y/frame/index stable all 50 cycles; after ready rises, the next entry follows.
- base=510, len=4, phase=3 -> frame_number=1 (wrap mod 512); len=0 entry -> phase stays 0, frame=base every scan.
- new_frame pulsed during a busy scan -> overrun=1 and stays high; divider is unchanged (animation timing same as without the extra pulse).
- wr_en to entry 3 (x=99) while entry 3 is held unaccepted -> outputs keep the old x; the next scan shows x=99 and phase 0.

Source files
------------

// File: rtl/sprite_sequencer.sv
// ---------------------------------------------------------------------------
// sprite_sequencer
//
// Holds the table of on-screen sprites written by game logic. Once per video
// frame (on new_frame, at the start of vertical blank) it walks the table and
// streams every active sprite's (x, y, absolute spritesheet frame) to the
// graphics stage over a valid/ready handshake. It also owns sprite animation:
// each entry has a phase that advances every ANIM_DIV video frames and wraps
// at that entry's animation length.
//
// Ports:
//   clk_pixel            pixel clock (only clock)
//   sys_rst              asynchronous active-high reset
//   new_frame            one-cycle pulse at start of vertical blank
//   wr_en / wr_*         table write port (index, active, x, y, base, length)
//   sprite_ready         downstream accepts the presented sprite
//   sprite_valid         presented sprite is valid
//   sprite_x/_y          sprite position
//   sprite_frame_number  (base + phase) mod NUM_FRAMES
//   sprite_index         table entry being presented
//   busy                 a scan is in progress
//   list_done            one-cycle pulse when a scan completes
//   overrun              sticky: new_frame arrived while busy
// ---------------------------------------------------------------------------
module sprite_sequencer #(
    parameter int MAX_SPRITES  = 16,
    parameter int NUM_FRAMES   = 512,
    parameter int WIDTH        = 1280,
    parameter int HEIGHT       = 720,
    parameter int ANIM_DIV     = 6,
    parameter int MAX_ANIM_LEN = 8,
    localparam int IW = $clog2(MAX_SPRITES),
    localparam int FW = $clog2(NUM_FRAMES),
    localparam int XW = $clog2(WIDTH),
    localparam int YW = $clog2(HEIGHT),
    localparam int LW = $clog2(MAX_ANIM_LEN + 1)
) (
    input  logic          clk_pixel,
    input  logic          sys_rst,
    input  logic          new_frame,
    input  logic          wr_en,
    input  logic [IW-1:0] wr_index,
    input  logic          wr_active,
    input  logic [XW-1:0] wr_x,
    input  logic [YW-1:0] wr_y,
    input  logic [FW-1:0] wr_base_frame,
    input  logic [LW-1:0] wr_anim_len,
    input  logic          sprite_ready,
    output logic          sprite_valid,
    output logic [XW-1:0] sprite_x,
    output logic [YW-1:0] sprite_y,
    output logic [FW-1:0] sprite_frame_number,
    output logic [IW-1:0] sprite_index,
    output logic          busy,
    output logic          list_done,
    output logic          overrun
);

    localparam int DW = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;

    typedef enum logic [1:0] {IDLE, SCAN, DRAIN} state_t;

    state_t state_reg, state_next;

    logic [IW-1:0] scan_idx_reg;
    logic [DW-1:0] div_reg;
    logic          step_reg;
    logic          overrun_reg;
    logic          list_done_reg;
    logic          done_next;

    logic          valid_reg;
    logic [XW-1:0] x_reg;
    logic [YW-1:0] y_reg;
    logic [FW-1:0] frame_reg;
    logic [IW-1:0] index_reg;

    // Combinational read view of the table, one element per entry.
    logic          act_arr   [MAX_SPRITES];
    logic [XW-1:0] x_arr     [MAX_SPRITES];
    logic [YW-1:0] y_arr     [MAX_SPRITES];
    logic [FW-1:0] base_arr  [MAX_SPRITES];
    logic [LW-1:0] phase_arr [MAX_SPRITES];

    logic handshake, out_free, inspect, load, last_idx;
    logic cur_active;

    assign handshake  = valid_reg && sprite_ready;
    assign out_free   = !valid_reg || sprite_ready;
    assign cur_active = act_arr[scan_idx_reg];
    // Inactive entries are skipped even while the output is stalled; an
    // active entry waits until the output register can take it.
    assign inspect    = (state_reg == SCAN) && (out_free || !cur_active);
    assign load       = inspect && cur_active;
    assign last_idx   = (scan_idx_reg == IW'(MAX_SPRITES - 1));

    // ---------------------------------------------------------------
    // Sprite table entries
    // ---------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < MAX_SPRITES; gi++) begin : g_entry
            logic          active_reg;
            logic [XW-1:0] x_e_reg;
            logic [YW-1:0] y_e_reg;
            logic [FW-1:0] base_reg;
            logic [LW-1:0] len_reg;
            logic [LW-1:0] phase_reg;
            logic          wr_hit;
            logic          adv_hit;
            logic [LW-1:0] len_eff;
            logic [LW-1:0] phase_inc;

            assign wr_hit    = wr_en && (wr_index == IW'(gi));
            // Advance only when this entry is the one being accepted.
            assign adv_hit   = handshake && step_reg && (index_reg == IW'(gi));
            assign len_eff   = (len_reg == '0) ? LW'(1) : len_reg;
            assign phase_inc = phase_reg + LW'(1);

            always_ff @(posedge clk_pixel or posedge sys_rst) begin
                if (sys_rst) begin
                    active_reg <= 1'b0;
                    x_e_reg    <= '0;
                    y_e_reg    <= '0;
                    base_reg   <= '0;
                    len_reg    <= '0;
                    phase_reg  <= '0;
                end else if (wr_hit) begin
                    // A write restarts the animation and overrides any
                    // advance from a simultaneous handshake.
                    active_reg <= wr_active;
                    x_e_reg    <= wr_x;
                    y_e_reg    <= wr_y;
                    base_reg   <= wr_base_frame;
                    len_reg    <= wr_anim_len;
                    phase_reg  <= '0;
                end else if (adv_hit) begin
                    phase_reg  <= (phase_inc >= len_eff) ? '0 : phase_inc;
                end
            end

            assign act_arr[gi]   = active_reg;
            assign x_arr[gi]     = x_e_reg;
            assign y_arr[gi]     = y_e_reg;
            assign base_arr[gi]  = base_reg;
            assign phase_arr[gi] = phase_reg;
        end
    endgenerate

    // ---------------------------------------------------------------
    // FSM: state register
    // ---------------------------------------------------------------
    always_ff @(posedge clk_pixel or posedge sys_rst) begin
        if (sys_rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // FSM: next state
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (new_frame) begin
                    state_next = SCAN;
                end
            end
            SCAN: begin
                if (inspect && last_idx) begin
                    if (load || !out_free) begin
                        state_next = DRAIN;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            DRAIN: begin
                if (out_free) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        busy      = (state_reg != IDLE);
        done_next = (state_reg != IDLE) && (state_next == IDLE);
    end

    // ---------------------------------------------------------------
    // Scan index, animation divider, status flags
    // ---------------------------------------------------------------
    always_ff @(posedge clk_pixel or posedge sys_rst) begin
        if (sys_rst) begin
            scan_idx_reg  <= '0;
            div_reg       <= '0;
            step_reg      <= 1'b0;
            overrun_reg   <= 1'b0;
            list_done_reg <= 1'b0;
        end else begin
            list_done_reg <= done_next;
            if (state_reg == IDLE) begin
                if (new_frame) begin
                    scan_idx_reg <= '0;
                    if (div_reg == DW'(ANIM_DIV - 1)) begin
                        div_reg  <= '0;
                        step_reg <= 1'b1;
                    end else begin
                        div_reg  <= div_reg + DW'(1);
                        step_reg <= 1'b0;
                    end
                end
            end else begin
                if (new_frame) begin
                    overrun_reg <= 1'b1;
                end
                if (inspect && !last_idx) begin
                    scan_idx_reg <= scan_idx_reg + IW'(1);
                end
            end
        end
    end

    // ---------------------------------------------------------------
    // Output register: refills when empty or on handshake
    // ---------------------------------------------------------------
    always_ff @(posedge clk_pixel or posedge sys_rst) begin
        if (sys_rst) begin
            valid_reg <= 1'b0;
            x_reg     <= '0;
            y_reg     <= '0;
            frame_reg <= '0;
            index_reg <= '0;
        end else if (load) begin
            valid_reg <= 1'b1;
            x_reg     <= x_arr[scan_idx_reg];
            y_reg     <= y_arr[scan_idx_reg];
            // Modulo NUM_FRAMES falls out of the FW-bit truncation.
            frame_reg <= base_arr[scan_idx_reg] + FW'(phase_arr[scan_idx_reg]);
            index_reg <= scan_idx_reg;
        end else if (handshake) begin
            valid_reg <= 1'b0;
        end
    end

    assign sprite_valid        = valid_reg;
    assign sprite_x            = x_reg;
    assign sprite_y            = y_reg;
    assign sprite_frame_number = frame_reg;
    assign sprite_index        = index_reg;
    assign list_done           = list_done_reg;
    assign overrun             = overrun_reg;

endmodule

// File: tb/tb_sprite_sequencer.sv
// ---------------------------------------------------------------------------
// tb_sprite_sequencer
//
// Directed bench for sprite_sequencer (ANIM_DIV = 2). Expected sprites are
// pushed to a scoreboard queue before each scan; a monitor pops and compares
// on every handshake. Control-flow checks (reset, hold stability, overrun,
// scan length) run in the stimulus process.
// ---------------------------------------------------------------------------
module tb_sprite_sequencer;

    localparam int IW = 4;
    localparam int FW = 9;
    localparam int XW = 11;
    localparam int YW = 10;
    localparam int LW = 4;

    logic          clk_pixel = 1'b0;
    logic          sys_rst;
    logic          new_frame;
    logic          wr_en;
    logic [IW-1:0] wr_index;
    logic          wr_active;
    logic [XW-1:0] wr_x;
    logic [YW-1:0] wr_y;
    logic [FW-1:0] wr_base_frame;
    logic [LW-1:0] wr_anim_len;
    logic          sprite_ready;
    logic          sprite_valid;
    logic [XW-1:0] sprite_x;
    logic [YW-1:0] sprite_y;
    logic [FW-1:0] sprite_frame_number;
    logic [IW-1:0] sprite_index;
    logic          busy;
    logic          list_done;
    logic          overrun;

    sprite_sequencer #(
        .MAX_SPRITES (16),
        .NUM_FRAMES  (512),
        .WIDTH       (1280),
        .HEIGHT      (720),
        .ANIM_DIV    (2),
        .MAX_ANIM_LEN(8)
    ) dut (
        .clk_pixel          (clk_pixel),
        .sys_rst            (sys_rst),
        .new_frame          (new_frame),
        .wr_en              (wr_en),
        .wr_index           (wr_index),
        .wr_active          (wr_active),
        .wr_x               (wr_x),
        .wr_y               (wr_y),
        .wr_base_frame      (wr_base_frame),
        .wr_anim_len        (wr_anim_len),
        .sprite_ready       (sprite_ready),
        .sprite_valid       (sprite_valid),
        .sprite_x           (sprite_x),
        .sprite_y           (sprite_y),
        .sprite_frame_number(sprite_frame_number),
        .sprite_index       (sprite_index),
        .busy               (busy),
        .list_done          (list_done),
        .overrun            (overrun)
    );

    always #5 clk_pixel = ~clk_pixel;

    int vectors    = 0;
    int miscompares = 0;
    logic [63:0] sb[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] pk(input int idx, input int x, input int y, input int f);
        return (64'(idx) << 30) | (64'(x) << 19) | (64'(y) << 9) | 64'(f);
    endfunction

    function automatic logic [63:0] outs();
        return pk(int'(sprite_index), int'(sprite_x), int'(sprite_y), int'(sprite_frame_number));
    endfunction

    // Monitor: every accepted sprite must match the head of the scoreboard.
    always @(negedge clk_pixel) begin
        if (!sys_rst && sprite_valid && sprite_ready) begin
            if (sb.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_sprite: got 0x%0h expected none at %0t", outs(), $time);
            end else begin
                logic [63:0] exp;
                exp = sb.pop_front();
                check("sprite", outs(), exp);
                $display("sprite idx=%0d x=%0d y=%0d frame=%0d", sprite_index, sprite_x,
                         sprite_y, sprite_frame_number);
            end
        end
    end

    task automatic tick();
        @(posedge clk_pixel);
        #1;
    endtask

    task automatic write(input int idx, input int act, input int x, input int y,
                         input int base, input int len);
        wr_index      = IW'(idx);
        wr_active     = act[0];
        wr_x          = XW'(x);
        wr_y          = YW'(y);
        wr_base_frame = FW'(base);
        wr_anim_len   = LW'(len);
        wr_en         = 1'b1;
        tick();
        wr_en         = 1'b0;
    endtask

    task automatic push(input int idx, input int x, input int y, input int f);
        sb.push_back(pk(idx, x, y, f));
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (n < 300) begin
            tick();
            n++;
            if (list_done) break;
        end
        check("list_done", {63'd0, list_done}, 64'd1);
        check("busy_at_done", {63'd0, busy}, 64'd0);
    endtask

    task automatic run_frame(output int n);
        new_frame = 1'b1;
        tick();
        new_frame = 1'b0;
        wait_done(n);
    endtask

    function automatic logic [63:0] all_outs();
        return {26'd0, sprite_valid, busy, list_done, overrun, sprite_x, sprite_y,
                sprite_frame_number, sprite_index};
    endfunction

    int n;
    int e0_exp[17]  = '{100, 100, 101, 101, 102, 102, 103, 103, 100, 100,
                        101, 101, 102, 102, 103, 103, 100};
    int e15_exp[7]  = '{510, 510, 511, 511, 0, 0, 1};
    int e0_tail[3]  = '{101, 101, 102};
    int e15_tail[3] = '{510, 510, 511};

    initial begin
        sys_rst = 1'b1; new_frame = 1'b0; wr_en = 1'b0; wr_index = '0; wr_active = 1'b0;
        wr_x = '0; wr_y = '0; wr_base_frame = '0; wr_anim_len = '0; sprite_ready = 1'b1;
        tick(); tick();
        check("reset_outputs", all_outs(), 64'd0);
        sys_rst = 1'b0;
        tick();

        // Three active entries stream in index order.
        write(0, 1, 10, 1, 5, 1);
        write(3, 1, 20, 2, 6, 1);
        write(15, 1, 30, 3, 7, 1);
        push(0, 10, 1, 5); push(3, 20, 2, 6); push(15, 30, 3, 7);
        run_frame(n);
        check("sb_empty_basic", 64'(sb.size()), 64'd0);

        // Reset mid-scan with a sprite held on the outputs.
        sprite_ready = 1'b0;
        new_frame = 1'b1; tick(); new_frame = 1'b0;
        n = 0;
        while (!sprite_valid && n < 50) begin tick(); n++; end
        check("valid_before_reset", {63'd0, sprite_valid}, 64'd1);
        #2 sys_rst = 1'b1;
        #1 check("async_reset_outputs", all_outs(), 64'd0);
        sb.delete();
        tick(); tick();
        sys_rst = 1'b0;
        sprite_ready = 1'b1;
        tick();

        // Animation sequence; entry 15 (base 510) joins at frame 11.
        write(0, 1, 10, 1, 100, 4);
        write(3, 1, 20, 2, 200, 0);
        for (int f = 1; f <= 17; f++) begin
            if (f == 11) write(15, 1, 30, 3, 510, 4);
            push(0, 10, 1, e0_exp[f-1]);
            push(3, 20, 2, 200);
            if (f >= 11) push(15, 30, 3, e15_exp[f-11]);
            run_frame(n);
            check("sb_empty_anim", 64'(sb.size()), 64'd0);
        end
        check("overrun_clear", {63'd0, overrun}, 64'd0);

        // Frame 18: stalled output, extra new_frame, write to the held entry.
        sprite_ready = 1'b0;
        push(0, 10, 1, 100); push(3, 20, 2, 200); push(15, 30, 3, 1);
        new_frame = 1'b1; tick(); new_frame = 1'b0;
        n = 0;
        while (!sprite_valid && n < 50) begin tick(); n++; end
        check("valid_rise", {63'd0, sprite_valid}, 64'd1);
        for (int i = 0; i < 50; i++) begin
            check("hold_stable", {sprite_valid, outs()[62:0]}, {1'b1, pk(0, 10, 1, 100)[62:0]});
            if (i == 10) new_frame = 1'b1;
            tick();
            new_frame = 1'b0;
        end
        check("overrun_set", {63'd0, overrun}, 64'd1);
        sprite_ready = 1'b1; tick(); sprite_ready = 1'b0;
        check("next_entry", outs(), pk(3, 20, 2, 200));
        write(3, 1, 99, 2, 200, 0);
        check("held_after_write", outs(), pk(3, 20, 2, 200));
        sprite_ready = 1'b1;
        wait_done(n);
        check("sb_empty_hold", 64'(sb.size()), 64'd0);

        // Frames 19-21: divider unaffected by the ignored pulse; new x visible.
        for (int f = 0; f < 3; f++) begin
            push(0, 10, 1, e0_tail[f]);
            push(3, 99, 2, 200);
            push(15, 30, 3, e15_tail[f]);
            run_frame(n);
            check("sb_empty_tail", 64'(sb.size()), 64'd0);
        end
        check("overrun_sticky", {63'd0, overrun}, 64'd1);

        // All entries inactive: bare scan of MAX_SPRITES cycles.
        write(0, 0, 0, 0, 0, 0);
        write(3, 0, 0, 0, 0, 0);
        write(15, 0, 0, 0, 0, 0);
        run_frame(n);
        check("empty_scan_cycles", 64'(n), 64'd16);
        tick(); tick();
        check("sb_empty_final", 64'(sb.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
